// File: rtl/gain_ramp.sv
// Pipelined signed sample x unsigned fixed-point gain with saturation
// and per-sample gain ramping to avoid zipper noise on gain changes.
module gain_ramp #(
    parameter int SAMPLE_W  = 16,
    parameter int GAIN_W    = 16,
    parameter int FRAC_BITS = 12,
    parameter int OUT_W     = 16,
    parameter int RAMP_STEP = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic        [GAIN_W-1:0]   i_gain,
    input  logic                       i_gain_load,
    output logic                       o_valid,
    output logic signed [OUT_W-1:0]    o_sample,
    output logic                       o_clip,
    output logic                       o_ramping
);

    localparam int PW = SAMPLE_W + GAIN_W + 1;

    localparam logic [GAIN_W-1:0] UNITY  = GAIN_W'(1 << FRAC_BITS);
    localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(RAMP_STEP);
    localparam logic [GAIN_W:0]   STEP_X = (GAIN_W + 1)'(RAMP_STEP);

    localparam logic signed [PW-1:0] QMAX =
        {{(PW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [PW-1:0] QMIN =
        {{(PW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic        [GAIN_W-1:0] target;
    logic        [GAIN_W-1:0] cur;
    logic                     v1;
    logic signed [PW-1:0]     p;

    logic        [GAIN_W-1:0] tgt_nx;
    logic        [GAIN_W-1:0] ramp_nx;
    logic        [GAIN_W:0]   up_x;
    logic        [GAIN_W:0]   dn_x;
    logic signed [PW-1:0]     s_ext;
    logic signed [PW-1:0]     g_ext;
    logic signed [PW-1:0]     q;
    logic signed [OUT_W-1:0]  sat;
    logic                     clip;

    // Ramp toward the target as it will be after this cycle's load,
    // using one extra bit so the step never wraps.
    always_comb begin
        tgt_nx  = i_gain_load ? i_gain : target;
        up_x    = {1'b0, cur} + STEP_X;
        dn_x    = {1'b0, tgt_nx} + STEP_X;
        ramp_nx = cur;
        if (STEP_X == '0 || cur == tgt_nx) begin
            ramp_nx = tgt_nx;
        end else if (cur < tgt_nx) begin
            ramp_nx = (up_x >= {1'b0, tgt_nx}) ? tgt_nx : cur + STEP_G;
        end else begin
            ramp_nx = (dn_x >= {1'b0, cur}) ? tgt_nx : cur - STEP_G;
        end
    end

    always_comb begin
        s_ext = PW'(i_sample);
        g_ext = PW'($signed({1'b0, cur}));
        q     = p >>> FRAC_BITS;
        sat   = q[OUT_W-1:0];
        clip  = 1'b0;
        if (q > QMAX) begin
            sat  = QMAX[OUT_W-1:0];
            clip = 1'b1;
        end else if (q < QMIN) begin
            sat  = QMIN[OUT_W-1:0];
            clip = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            target    <= UNITY;
            cur       <= UNITY;
            v1        <= 1'b0;
            p         <= '0;
            o_valid   <= 1'b0;
            o_sample  <= '0;
            o_clip    <= 1'b0;
            o_ramping <= 1'b0;
        end else begin
            o_ramping <= (cur != target);
            if (i_gain_load) begin
                target <= i_gain;
            end
            v1 <= i_valid;
            if (i_valid) begin
                p   <= s_ext * g_ext;
                cur <= ramp_nx;
            end
            o_valid <= v1;
            if (v1) begin
                o_sample <= sat;
                o_clip   <= clip;
            end
        end
    end

endmodule

// File: tb/tb_gain_ramp.sv
// Randomised scoreboard bench for gain_ramp: a ramping build and an
// immediate-jump build share stimulus, each checked against a plain model.
module tb_gain_ramp;

    typedef struct {
        int s;
        bit c;
        int cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid = 1'b0;
    logic signed [15:0] sample = '0;
    logic        [15:0] gain = '0;
    logic               load = 1'b0;

    logic               ov [2];
    logic signed [15:0] os [2];
    logic               oc [2];
    logic               orp [2];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    int cur_m [2];
    int tgt_m [2];
    int step_m [2] = '{16, 0};
    bit ram_exp [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gain_ramp #(.RAMP_STEP(16)) u_ramp (
        .i_clk(clk), .i_rst(rst), .i_valid(valid),
        .i_sample(sample), .i_gain(gain), .i_gain_load(load),
        .o_valid(ov[0]), .o_sample(os[0]),
        .o_clip(oc[0]), .o_ramping(orp[0])
    );

    gain_ramp #(.RAMP_STEP(0)) u_jump (
        .i_clk(clk), .i_rst(rst), .i_valid(valid),
        .i_sample(sample), .i_gain(gain), .i_gain_load(load),
        .o_valid(ov[1]), .o_sample(os[1]),
        .o_clip(oc[1]), .o_ramping(orp[1])
    );

    // Reference: exact product, floor-divide by 4096, clamp to 16 bits.
    function automatic void model_out(input int s, input int g,
                                      output int y, output bit c);
        longint pr;
        longint qq;
        pr = longint'(s) * longint'(g);
        qq = pr >>> 12;
        c  = 1'b0;
        y  = int'(qq);
        if (qq > 32767) begin
            y = 32767;
            c = 1'b1;
        end else if (qq < -32768) begin
            y = -32768;
            c = 1'b1;
        end
    endfunction

    function automatic int ramp_to(input int c, input int t, input int st);
        if (st == 0) return t;
        if (c < t) return (c + st < t) ? c + st : t;
        if (c > t) return (c - st > t) ? c - st : t;
        return c;
    endfunction

    task automatic step(input bit v, input int s, input bit ld, input int g);
        exp_t e;
        int   y;
        bit   c;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (orp[k] !== ram_exp[k]) begin
                n_errors++;
                $display("FAIL ramping[%0d] cyc=%0d got=%b want=%b",
                         k, cyc, orp[k], ram_exp[k]);
            end
        end
        valid  = v;
        sample = 16'(s);
        load   = ld;
        gain   = 16'(g);
        for (int k = 0; k < 2; k++) begin
            ram_exp[k] = (cur_m[k] != tgt_m[k]);
            if (v) begin
                model_out(s, cur_m[k], y, c);
                e.s   = y;
                e.c   = c;
                e.cyc = cyc + 2;
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
            if (ld) tgt_m[k] = g;
            if (v) cur_m[k] = ramp_to(cur_m[k], tgt_m[k], step_m[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst   = 1'b1;
        valid = 1'b0;
        load  = 1'b0;
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            cur_m[k]   = 4096;
            tgt_m[k]   = 4096;
            ram_exp[k] = 1'b0;
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (ov[k] !== 1'b0 || os[k] !== 16'sd0 ||
                oc[k] !== 1'b0 || orp[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_state[%0d] got v=%b s=%0d c=%b r=%b want 0",
                         k, ov[k], os[k], oc[k], orp[k]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
    endtask

    // Monitor: every output strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t               e;
        logic signed [15:0] es;
        for (int k = 0; k < 2; k++) begin
            if (ov[k] === 1'b1) begin
                n_checks++;
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    n_errors++;
                    $display("FAIL unexpected_valid[%0d] cyc=%0d got s=%0d want none",
                             k, cyc, os[k]);
                end else begin
                    e  = (k == 0) ? q0.pop_front() : q1.pop_front();
                    es = 16'(e.s);
                    if (os[k] !== es || oc[k] !== e.c || cyc != e.cyc) begin
                        n_errors++;
                        $display("FAIL sample[%0d] got s=%0d c=%b cyc=%0d want s=%0d c=%b cyc=%0d",
                                 k, os[k], oc[k], cyc, es, e.c, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int s;
        do_reset();

        step(1'b1, 1000, 1'b0, 0);
        idle(3);

        step(1'b0, 0, 1'b1, 4160);
        for (int i = 0; i < 6; i++) step(1'b1, 4096, 1'b0, 0);
        idle(3);

        step(1'b0, 0, 1'b1, 32768);
        step(1'b1, 16000, 1'b0, 0);
        step(1'b1, -20000, 1'b0, 0);
        step(1'b0, 0, 1'b1, 65535);
        step(1'b1, -32768, 1'b0, 0);
        step(1'b1, 32767, 1'b0, 0);
        step(1'b0, 0, 1'b1, 0);
        step(1'b1, -32768, 1'b0, 0);
        step(1'b1, 12345, 1'b0, 0);
        idle(3);

        do_reset();
        step(1'b1, -3, 1'b1, 2048);
        step(1'b1, -3, 1'b0, 0);
        step(1'b1, -3, 1'b0, 0);
        idle(3);

        do_reset();
        for (int i = 0; i < 100; i++) begin
            s = int'($signed(16'($urandom)));
            step(1'b1, s, 1'b0, 0);
        end
        idle(3);

        step(1'b1, 1234, 1'b0, 0);
        do_reset();
        step(1'b1, 1000, 1'b0, 0);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            s = int'($signed(16'($urandom)));
            step($urandom_range(0, 3) != 0, s,
                 $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                             : int'($urandom_range(0, 8192)));
        end
        idle(4);

        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_errors++;
            $display("FAIL drain got pending=%0d/%0d want 0/0",
                     q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
